game_state_sequencer: RTL and testbench
=======================================

GAME_STATE_SEQUENCER -- requirements
Module: game_state_sequencer

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- LIVES_INIT, 3: lives loaded at game start, range 1..3.
- PELLETS_TOTAL, 64: pellets per level, range 1..255.
- FRIGHT_FRAMES, 180: frames frightened mode lasts.
- PAUSE_FRAMES, 60: frames spent in DYING or CLEAR.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk, in, 1: system clock.
- resetN, in, 1: asynchronous active-low reset.
- startOfFrame, in, 1: one-cycle pulse per frame.
- start_key, in, 1: level signal from the start key.
- pellet_hit, in, 1: single-cycle pulse, smiley ate a pellet.
- power_hit, in, 1: single-cycle pulse, smiley ate a power pellet.
- ghost_hit, in, 1: single-cycle pulse, smiley touched a ghost.
- state, out, 3: IDLE=0, PLAY=1, DYING=2, CLEAR=3, OVER=4.
- lives, out, 2: remaining lives.
- score, out, 16: binary score.
- frightened, out, 1: ghosts are edible.
- freeze, out, 1: movement halted.
- ghost_eaten_pulse, out, 1: one-cycle pulse when a ghost is eaten.

Function
REQ-003 SHALL register all outputs; the response to an input pulse SHALL be visible on the cycle after the pulse.
REQ-004 SHALL detect start_key rising edges with a registered previous value; only an edge acts.
REQ-005 In IDLE or OVER, a start edge SHALL enter PLAY and load score=0, lives=LIVES_INIT, pellets_left=PELLETS_TOTAL and frightened=0.
REQ-006 In PLAY, pellet_hit SHALL add 10 to score and decrement pellets_left.
REQ-007 When pellets_left goes from 1 to 0, the block SHALL enter CLEAR on the next cycle.
REQ-008 In PLAY, power_hit SHALL add 50 to score, decrement pellets_left, set frightened=1 and load the fright counter with FRIGHT_FRAMES.
REQ-009 A power_hit while already frightened SHALL reload the fright counter.
REQ-010 The fright counter SHALL decrement only on startOfFrame; when it reaches 0, frightened SHALL clear on that same update.
REQ-011 In PLAY, ghost_hit while frightened SHALL add 200 to score and assert ghost_eaten_pulse for exactly 1 cycle.
REQ-012 In PLAY, ghost_hit while not frightened SHALL enter DYING, decrement lives, clear frightened and load the pause counter with PAUSE_FRAMES.
REQ-013 On simultaneous pulses in one cycle:
- A killing ghost_hit wins; pellet_hit and power_hit in that cycle are ignored.
- Otherwise all applicable score increments SHALL sum in the same cycle, and pellets_left SHALL decrement by the number of pellet-type hits.
REQ-014 score SHALL saturate at 16'hFFFF and never wrap.
REQ-015 DYING: freeze=1; the pause counter decrements on startOfFrame. At expiry:
- lives==0 -> OVER.
- otherwise -> PLAY, with pellets_left preserved.
REQ-016 CLEAR: freeze=1; after PAUSE_FRAMES frames, go to PLAY with pellets_left=PELLETS_TOTAL, and score and lives kept.
REQ-017 freeze SHALL be 1 in IDLE, DYING, CLEAR and OVER, and 0 in PLAY.
REQ-018 Inputs arriving outside PLAY SHALL be ignored, except start_key.
REQ-019 Undefined state encodings SHALL return to IDLE on the next cycle.

Reset
REQ-020 Asserting resetN low, at any time including mid-frame or mid-pause, SHALL immediately force:
- state=IDLE, score=0, lives=LIVES_INIT;
- frightened=0, freeze=1, ghost_eaten_pulse=0;
- all counters=0, start_key history=0.
REQ-021 After reset release, the first start edge SHALL be required before PLAY is entered.

Configuration
REQ-022 Macro FRIGHT_MODE_EN:
- Defined: power pellets and frightened mode behave per REQ-008..REQ-011.
- Undefined: power_hit is treated exactly as pellet_hit (+10, decrements pellets_left); frightened and ghost_eaten_pulse are constant 0; every ghost_hit in PLAY kills; the fright counter is not synthesised.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset, start edge, 64 pellet_hit pulses -> score=640; CLEAR on the cycle after the 64th; PLAY after 60 frames with pellets_left=64.
- Macro on: power_hit, then ghost_hit after 10 frames -> score=250, ghost_eaten_pulse high 1 cycle; frightened=0 after frame 180.
- Three non-frightened ghost_hits, each followed by a 60-frame pause -> lives 3,2,1,0, then OVER; a start edge restarts with score=0, lives=3.
- ghost_hit and pellet_hit in the same cycle while not frightened -> DYING, score unchanged, pellets_left unchanged.
- Score preset near saturation (0xFFF0) plus ghost_eaten -> score=0xFFFF; resetN pulsed during DYING -> IDLE with all outputs at reset values.
- Macro off: power_hit -> score+10, frightened stays 0, and a following ghost_hit kills.

Source files
------------

// File: rtl/game_state_sequencer.sv
// Maze game sequencer: lives, score, pellet count and play/pause phases.
// Optional frightened mode (power pellets, edible ghosts) under FRIGHT_MODE_EN.
module game_state_sequencer #(
    parameter int LIVES_INIT    = 3,
    parameter int PELLETS_TOTAL = 64,
    parameter int FRIGHT_FRAMES = 180,
    parameter int PAUSE_FRAMES  = 60
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        start_key,
    input  logic        pellet_hit,
    input  logic        power_hit,
    input  logic        ghost_hit,
    output logic [2:0]  state,
    output logic [1:0]  lives,
    output logic [15:0] score,
    output logic        frightened,
    output logic        freeze,
    output logic        ghost_eaten_pulse
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PLAY  = 3'd1;
    localparam logic [2:0] ST_DYING = 3'd2;
    localparam logic [2:0] ST_CLEAR = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    localparam int PW = $clog2(PAUSE_FRAMES + 2);

    localparam logic [PW-1:0] PAUSE_LD   = PW'(PAUSE_FRAMES);
    localparam logic [7:0]    PELLETS_LD = 8'(PELLETS_TOTAL);
    localparam logic [1:0]    LIVES_LD   = 2'(LIVES_INIT);

    logic [2:0]    state_q, state_d;
    logic [1:0]    lives_q, lives_d;
    logic [15:0]   score_q, score_d;
    logic [7:0]    pellets_q, pellets_d;
    logic [PW-1:0] pause_q, pause_d;
    logic          start_q;
    logic          freeze_q, freeze_d;

    logic          start_edge;
    logic          kill;
    logic [8:0]    inc;
    logic [16:0]   sum;
    logic [15:0]   score_sat;
    logic [7:0]    nhits;

`ifdef FRIGHT_MODE_EN
    localparam int FW = $clog2(FRIGHT_FRAMES + 2);
    localparam logic [FW-1:0] FRIGHT_LD = FW'(FRIGHT_FRAMES);

    logic          fright_q, fright_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          eaten_q, eaten_d;
    logic          eat_ghost;

    assign eat_ghost = ghost_hit & fright_q;
    assign kill      = ghost_hit & ~fright_q;
    assign inc       = (pellet_hit ? 9'd10  : 9'd0)
                     + (power_hit  ? 9'd50  : 9'd0)
                     + (eat_ghost  ? 9'd200 : 9'd0);
`else
    assign kill = ghost_hit;
    assign inc  = (pellet_hit ? 9'd10 : 9'd0)
                + (power_hit  ? 9'd10 : 9'd0);
`endif

    assign start_edge = start_key & ~start_q;
    assign nhits      = 8'(pellet_hit) + 8'(power_hit);
    assign sum        = {1'b0, score_q} + 17'(inc);
    assign score_sat  = sum[16] ? 16'hFFFF : sum[15:0];

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        score_d   = score_q;
        pellets_d = pellets_q;
        pause_d   = pause_q;
`ifdef FRIGHT_MODE_EN
        fright_d  = fright_q;
        fcnt_d    = fcnt_q;
        eaten_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_edge) begin
                    state_d   = ST_PLAY;
                    score_d   = 16'd0;
                    lives_d   = LIVES_LD;
                    pellets_d = PELLETS_LD;
`ifdef FRIGHT_MODE_EN
                    fright_d  = 1'b0;
                    fcnt_d    = '0;
`endif
                end
            end
            ST_PLAY: begin
                if (kill) begin
                    state_d = ST_DYING;
                    lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                    pause_d = PAUSE_LD;
`ifdef FRIGHT_MODE_EN
                    fright_d = 1'b0;
                    fcnt_d   = '0;
`endif
                end else begin
                    score_d   = score_sat;
                    pellets_d = (nhits >= pellets_q) ? 8'd0
                                                     : pellets_q - nhits;
`ifdef FRIGHT_MODE_EN
                    eaten_d = eat_ghost;
                    if (power_hit) begin
                        fright_d = 1'b1;
                        fcnt_d   = FRIGHT_LD;
                    end else if (fright_q && startOfFrame) begin
                        fcnt_d = (fcnt_q != '0) ? fcnt_q - FW'(1) : '0;
                        if (fcnt_q <= FW'(1))
                            fright_d = 1'b0;
                    end
`endif
                    // last pellet eaten: level cleared
                    if (nhits != 8'd0 && pellets_d == 8'd0) begin
                        state_d = ST_CLEAR;
                        pause_d = PAUSE_LD;
`ifdef FRIGHT_MODE_EN
                        fright_d = 1'b0;
                        fcnt_d   = '0;
`endif
                    end
                end
            end
            ST_DYING: begin
                if (startOfFrame) begin
                    if (pause_q <= PW'(1)) begin
                        pause_d = '0;
                        state_d = (lives_q == 2'd0) ? ST_OVER : ST_PLAY;
                    end else begin
                        pause_d = pause_q - PW'(1);
                    end
                end
            end
            ST_CLEAR: begin
                if (startOfFrame) begin
                    if (pause_q <= PW'(1)) begin
                        pause_d   = '0;
                        state_d   = ST_PLAY;
                        pellets_d = PELLETS_LD;
                    end else begin
                        pause_d = pause_q - PW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        freeze_d = (state_d != ST_PLAY);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= ST_IDLE;
            lives_q   <= LIVES_LD;
            score_q   <= 16'd0;
            pellets_q <= 8'd0;
            pause_q   <= '0;
            start_q   <= 1'b0;
            freeze_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            score_q   <= score_d;
            pellets_q <= pellets_d;
            pause_q   <= pause_d;
            start_q   <= start_key;
            freeze_q  <= freeze_d;
        end
    end

`ifdef FRIGHT_MODE_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fright_q <= 1'b0;
            fcnt_q   <= '0;
            eaten_q  <= 1'b0;
        end else begin
            fright_q <= fright_d;
            fcnt_q   <= fcnt_d;
            eaten_q  <= eaten_d;
        end
    end

    assign frightened        = fright_q;
    assign ghost_eaten_pulse = eaten_q;
`else
    assign frightened        = 1'b0;
    assign ghost_eaten_pulse = 1'b0;
`endif

    assign state = state_q;
    assign lives = lives_q;
    assign score = score_q;
    assign freeze = freeze_q;

endmodule

// File: tb/tb_game_state_sequencer.sv
// Directed bench for game_state_sequencer; expected values hand-computed.
// Frightened-mode scenarios are selected with FRIGHT_MODE_EN.
module tb_game_state_sequencer;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        start_key = 1'b0;
    logic        pellet_hit = 1'b0;
    logic        power_hit = 1'b0;
    logic        ghost_hit = 1'b0;
    logic [2:0]  state;
    logic [1:0]  lives;
    logic [15:0] score;
    logic        frightened;
    logic        freeze;
    logic        ghost_eaten_pulse;

    int n_cmp = 0;
    int n_bad = 0;
    int pl_left;

    game_state_sequencer dut (
        .clk               (clk),
        .resetN            (resetN),
        .startOfFrame      (startOfFrame),
        .start_key         (start_key),
        .pellet_hit        (pellet_hit),
        .power_hit         (power_hit),
        .ghost_hit         (ghost_hit),
        .state             (state),
        .lives             (lives),
        .score             (score),
        .frightened        (frightened),
        .freeze            (freeze),
        .ghost_eaten_pulse (ghost_eaten_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hit(input logic p, input logic w, input logic g);
        pellet_hit = p;
        power_hit  = w;
        ghost_hit  = g;
        tick();
        pellet_hit = 1'b0;
        power_hit  = 1'b0;
        ghost_hit  = 1'b0;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
        end
    endtask

    task automatic press_start();
        start_key = 1'b1;
        tick();
        start_key = 1'b0;
        tick();
    endtask

    task automatic eat(input int n);
        repeat (n) begin
            hit(1'b1, 1'b0, 1'b0);
            pl_left--;
            if (pl_left == 0) begin
                frames(60);
                pl_left = 64;
            end
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"}, state, 0);
        check({tag, "_score"}, score, 0);
        check({tag, "_lives"}, lives, 3);
        check({tag, "_freeze"}, freeze, 1);
        check({tag, "_fright"}, frightened, 0);
        check({tag, "_gep"}, ghost_eaten_pulse, 0);
    endtask

    initial begin
        repeat (3) tick();
        check_reset("rst");
        resetN = 1'b1;
        tick();
        tick();
        check("idle_hold", state, 0);

        press_start();
        check("start_state", state, 1);
        check("start_score", score, 0);
        check("start_lives", lives, 3);
        check("start_freeze", freeze, 0);

        repeat (63) hit(1'b1, 1'b0, 1'b0);
        check("pre_clear", state, 1);
        check("score_630", score, 630);
        hit(1'b1, 1'b0, 1'b0);
        check("clear_state", state, 3);
        check("score_640", score, 640);
        check("clear_freeze", freeze, 1);
        hit(1'b1, 1'b0, 1'b0);
        check("ignore_clear", score, 640);
        frames(59);
        check("clear_hold", state, 3);
        frames(1);
        check("clear_exit", state, 1);
        check("clear_exit_frz", freeze, 0);

        repeat (63) hit(1'b1, 1'b0, 1'b0);
        check("refill", state, 1);
        hit(1'b1, 1'b0, 1'b0);
        check("refill_clear", state, 3);
        check("score_1280", score, 1280);
        frames(60);

        hit(1'b1, 1'b0, 1'b1);
        check("combo_state", state, 2);
        check("combo_score", score, 1280);
        check("combo_lives", lives, 2);
        check("combo_freeze", freeze, 1);
        frames(60);
        check("combo_resume", state, 1);
        check("combo_lives2", lives, 2);
        repeat (63) hit(1'b1, 1'b0, 1'b0);
        check("kept_play", state, 1);
        hit(1'b1, 1'b0, 1'b0);
        check("kept_clear", state, 3);
        check("score_1920", score, 1920);
        frames(60);

        hit(1'b0, 1'b0, 1'b1);
        check("kill2_lives", lives, 1);
        frames(60);
        check("kill2_resume", state, 1);
        hit(1'b0, 1'b0, 1'b1);
        check("kill3_lives", lives, 0);
        start_key = 1'b1;
        frames(59);
        check("pause_hold", state, 2);
        frames(1);
        check("over_state", state, 4);
        check("over_freeze", freeze, 1);
        tick();
        check("no_edge", state, 4);
        hit(1'b1, 1'b0, 1'b0);
        check("over_ignore", score, 1920);
        start_key = 1'b0;
        tick();
        start_key = 1'b1;
        tick();
        check("restart_state", state, 1);
        check("restart_score", score, 0);
        check("restart_lives", lives, 3);
        start_key = 1'b0;
        tick();

`ifdef FRIGHT_MODE_EN
        hit(1'b0, 1'b1, 1'b0);
        check("power_score", score, 50);
        check("power_fright", frightened, 1);
        frames(10);
        hit(1'b0, 1'b0, 1'b1);
        check("eat_score", score, 250);
        check("eat_pulse", ghost_eaten_pulse, 1);
        check("eat_state", state, 1);
        tick();
        check("eat_pulse_end", ghost_eaten_pulse, 0);
        frames(169);
        check("fright_179", frightened, 1);
        frames(1);
        check("fright_180", frightened, 0);
        hit(1'b0, 1'b0, 1'b1);
        check("post_kill", state, 2);
        check("post_lives", lives, 2);
`else
        hit(1'b0, 1'b1, 1'b0);
        check("power_score", score, 10);
        check("power_fright", frightened, 0);
        check("power_state", state, 1);
        hit(1'b1, 1'b1, 1'b0);
        check("dual_score", score, 30);
        hit(1'b0, 1'b0, 1'b1);
        check("post_kill", state, 2);
        check("post_lives", lives, 2);
        check("post_gep", ghost_eaten_pulse, 0);
`endif

        frames(20);
        @(posedge clk);
        #3;
        resetN = 1'b0;
        #1;
        check_reset("arst");
        tick();
        resetN = 1'b1;
        tick();
        tick();
        check("arst_idle", state, 0);

        press_start();
        pl_left = 64;
`ifdef FRIGHT_MODE_EN
        eat(6547);
        check("sat_pre", score, 16'hFFBE);
        hit(1'b0, 1'b1, 1'b0);
        check("sat_fff0", score, 16'hFFF0);
        hit(1'b0, 1'b0, 1'b1);
        check("sat_ffff", score, 16'hFFFF);
        check("sat_gep", ghost_eaten_pulse, 1);
`else
        eat(6553);
        check("sat_pre", score, 16'hFFFA);
        hit(1'b1, 1'b0, 1'b0);
        check("sat_ffff", score, 16'hFFFF);
        hit(1'b1, 1'b0, 1'b0);
        check("sat_hold", score, 16'hFFFF);
`endif
        check("sat_state", state, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
